// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 raster constants and shared colours
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int XRES = H_VIS;
  localparam int YRES = V_VIS;

  localparam int SCROLL_WRAP = 640;

  localparam logic [23:0] BLACK       = 24'h00_00_00;
  localparam logic [23:0] SKY_COLOR   = 24'h87_ce_eb;
  localparam logic [23:0] CLOUD_COLOR = 24'hff_ff_ff;

endpackage

// File: rtl/scroll_accum.sv
// rtl/scroll_accum.sv - per-frame horizontal scroll offset, signed add modulo WRAP
module scroll_accum
  import vga_pkg::*;
#(
  parameter int WRAP = SCROLL_WRAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic       enable,
  input  logic [4:0] speed,
  output logic [9:0] xoffset
);

  localparam logic [10:0] WRAP11 = 11'(WRAP);

  logic [10:0] sum;
  logic [9:0]  wrapped;

  // |speed| < WRAP, so a single add or subtract always lands back in range
  always_comb begin
    sum     = {1'b0, xoffset} + {{6{speed[4]}}, speed};
    wrapped = sum[9:0];
    if (sum[10]) begin
      wrapped = 10'(sum + WRAP11);
    end else if (sum >= WRAP11) begin
      wrapped = 10'(sum - WRAP11);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xoffset <= '0;
    end else if (update && enable) begin
      xoffset <= wrapped;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, registered sync/blank/rgb decode, scroll offset
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          H_VIS       = vga_pkg::H_VIS,
  parameter int          H_FP        = vga_pkg::H_FP,
  parameter int          H_SYNC      = vga_pkg::H_SYNC,
  parameter int          H_BP        = vga_pkg::H_BP,
  parameter int          V_VIS       = vga_pkg::V_VIS,
  parameter int          V_FP        = vga_pkg::V_FP,
  parameter int          V_SYNC      = vga_pkg::V_SYNC,
  parameter int          V_BP        = vga_pkg::V_BP,
  parameter logic [23:0] BG_COLOR    = 24'h00_00_00,
  parameter int          SCROLL_WRAP = vga_pkg::SCROLL_WRAP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scroll_en,
  input  logic [4:0]  scroll_speed,
  output logic [9:0]  hcount_out,
  output logic        hsync_out,
  output logic [9:0]  vcount_out,
  output logic        vsync_out,
  output logic        blnk_out,
  output logic [23:0] rgb_out,
  output logic [9:0]  xoffset_out,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS10  = 10'(H_VIS);
  localparam logic [9:0] V_VIS10  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       blank_nxt;
  logic       scroll_strobe;

  always_comb begin
    h_nxt = hcount_out + 10'd1;
    v_nxt = vcount_out;
    if (hcount_out == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
    end
    blank_nxt = (h_nxt >= H_VIS10) || (v_nxt >= V_VIS10);
  end

  // Decodes use the next-state counters so every output describes the same pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      blnk_out    <= 1'b0;
      rgb_out     <= BG_COLOR;
      frame_start <= 1'b1;
    end else begin
      hcount_out  <= h_nxt;
      vcount_out  <= v_nxt;
      hsync_out   <= !((h_nxt >= HS_START) && (h_nxt <= HS_END));
      vsync_out   <= !((v_nxt >= VS_START) && (v_nxt <= VS_END));
      blnk_out    <= blank_nxt;
      rgb_out     <= blank_nxt ? 24'h0 : BG_COLOR;
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  // Last visible pixel: the offset moves once per frame, inside vertical blank
  assign scroll_strobe = (hcount_out == H_LAST) && (vcount_out == V_VIS10 - 10'd1);

  scroll_accum #(
    .WRAP(SCROLL_WRAP)
  ) u_scroll_accum (
    .clk    (clk),
    .rst    (rst),
    .update (scroll_strobe),
    .enable (scroll_en),
    .speed  (scroll_speed),
    .xoffset(xoffset_out)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (reduced and full raster)
module tb_vga_timing_gen;

  logic        clk;
  logic        rst;
  logic        scroll_en;
  logic [4:0]  scroll_speed;

  logic [9:0]  s_h, s_v, s_xo;
  logic        s_hs, s_vs, s_bl, s_fs;
  logic [23:0] s_rgb;

  logic [9:0]  f_h, f_v, f_xo;
  logic        f_hs, f_vs, f_bl, f_fs;
  logic [23:0] f_rgb;

  // Reduced raster: 25 clk per line, 19 lines, 475 clk per frame
  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .BG_COLOR(24'h12_34_56), .SCROLL_WRAP(640)
  ) dut (
    .clk(clk), .rst(rst), .scroll_en(scroll_en), .scroll_speed(scroll_speed),
    .hcount_out(s_h), .hsync_out(s_hs), .vcount_out(s_v), .vsync_out(s_vs),
    .blnk_out(s_bl), .rgb_out(s_rgb), .xoffset_out(s_xo), .frame_start(s_fs)
  );

  vga_timing_gen dut_full (
    .clk(clk), .rst(rst), .scroll_en(scroll_en), .scroll_speed(scroll_speed),
    .hcount_out(f_h), .hsync_out(f_hs), .vcount_out(f_v), .vsync_out(f_vs),
    .blnk_out(f_bl), .rgb_out(f_rgb), .xoffset_out(f_xo), .frame_start(f_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mh = 0, mv = 0, mx = 0, fh = 0, fv = 0;
  int cyc = 0;
  int last_fs = -1;
  logic [57:0] sb_q[$];
  logic [57:0] full_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [57:0] pix(input int h, input int v, input int hvis, input int hs0,
                                      input int hs1, input int vvis, input int vs0, input int vs1,
                                      input logic [23:0] bg, input int xo);
    logic hs, vs, bl;
    hs = !(h >= hs0 && h <= hs1);
    vs = !(v >= vs0 && v <= vs1);
    bl = (h >= hvis) || (v >= vvis);
    return {10'(h), 10'(v), hs, vs, bl, (bl ? 24'h0 : bg), 10'(xo), (h == 0 && v == 0)};
  endfunction

  task automatic step(input logic r, input logic en, input logic [4:0] sp);
    int s;
    rst = r; scroll_en = en; scroll_speed = sp;
    @(posedge clk);
    if (r) begin
      mh = 0; mv = 0; mx = 0; fh = 0; fv = 0;
      last_fs = -1;
    end else begin
      if (en && mh == 24 && mv == 11) begin
        s = mx + int'($signed(sp));
        if (s < 0) s += 640;
        else if (s >= 640) s -= 640;
        mx = s;
      end
      mh++;
      if (mh == 25) begin mh = 0; mv = (mv == 18) ? 0 : mv + 1; end
      fh++;
      if (fh == 800) begin fh = 0; fv = (fv == 524) ? 0 : fv + 1; end
    end
    sb_q.push_back(pix(mh, mv, 16, 18, 21, 12, 14, 15, 24'h12_34_56, mx));
    full_q.push_back(pix(fh, fv, 640, 656, 751, 480, 490, 491, 24'h0, 0));
    @(negedge clk);
    cyc++;
    check("pix", {6'd0, s_h, s_v, s_hs, s_vs, s_bl, s_rgb, s_xo, s_fs}, {6'd0, sb_q.pop_front()});
    check("pix_full", {6'd0, f_h, f_v, f_hs, f_vs, f_bl, f_rgb, f_xo, f_fs},
          {6'd0, full_q.pop_front()});
    if (s_fs) begin
      if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'd475);
      last_fs = cyc;
    end
  endtask

  task automatic run_frame(input logic en, input logic [4:0] sp);
    for (int i = 0; i < 475; i++) step(1'b0, en, sp);
  endtask

  initial begin
    rst = 1'b1; scroll_en = 1'b0; scroll_speed = 5'd0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 5'd0);
    check("rst_h", 64'(s_h), 64'd0);
    check("rst_v", 64'(s_v), 64'd0);
    check("rst_hsync", 64'(s_hs), 64'd1);
    check("rst_vsync", 64'(s_vs), 64'd1);
    check("rst_blnk", 64'(s_bl), 64'd0);
    check("rst_rgb", 64'(s_rgb), 64'h12_34_56);
    check("rst_xoff", 64'(s_xo), 64'd0);
    check("rst_fs", 64'(s_fs), 64'd1);

    step(1'b0, 1'b0, 5'd0);
    check("first_h", 64'(s_h), 64'd1);
    check("first_fs", 64'(s_fs), 64'd0);

    // Two full-size lines plus a few reduced frames
    for (int i = 0; i < 1999; i++) step(1'b0, 1'b0, 5'd0);
    check("full_v_after_2_lines", 64'(f_v), 64'd2);

    for (int f = 0; f < 42; f++) run_frame(1'b1, 5'd15);
    check("xoff_630", 64'(s_xo), 64'd630);
    run_frame(1'b1, 5'd5);
    check("xoff_635", 64'(s_xo), 64'd635);
    run_frame(1'b1, 5'd7);
    check("xoff_wrap_up", 64'(s_xo), 64'd2);
    run_frame(1'b1, 5'd3);
    check("xoff_5", 64'(s_xo), 64'd5);
    run_frame(1'b1, 5'h10);
    check("xoff_wrap_down", 64'(s_xo), 64'd629);

    // Speed jitters every cycle; only the value at the last visible pixel counts
    for (int i = 0; i < 475; i++) begin
      if (mh == 24 && mv == 11) step(1'b0, 1'b1, 5'd1);
      else step(1'b0, 1'b1, 5'($urandom_range(0, 31)));
    end
    check("xoff_sampled_speed", 64'(s_xo), 64'd630);
    run_frame(1'b0, 5'd9);
    check("xoff_held", 64'(s_xo), 64'd630);

    begin
      int n = 0;
      while (!(mh == 10 && mv == 7) && n < 500) begin
        step(1'b0, 1'b0, 5'd0);
        n++;
      end
      check("seek_mid_frame", 64'(mh == 10 && mv == 7), 64'd1);
    end
    step(1'b1, 1'b1, 5'd3);
    check("midrst_h", 64'(s_h), 64'd0);
    check("midrst_v", 64'(s_v), 64'd0);
    check("midrst_xoff", 64'(s_xo), 64'd0);
    check("midrst_hsync", 64'(s_hs), 64'd1);
    step(1'b0, 1'b0, 5'd0);
    check("after_midrst_h", 64'(s_h), 64'd1);
    for (int i = 0; i < 600; i++) step(1'b0, 1'b0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Head of the VGA video pipeline: generates the 640x480@60 raster (hcount, vcount, hsync, vsync, blank) and a background colour that every downstream drawing stage consumes and forwards. It also owns the per-frame horizontal scroll offset fed to the scrolling background stages. It is the transmitter end of the hcount/vcount/sync/blank/rgb pixel bus.

## Interface
Parameters:
- `H_VIS`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_VIS`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `BG_COLOR`, 24'h00_00_00: rgb driven on visible pixels
- `SCROLL_WRAP`, 640: xoffset modulus

Ports:
- `clk`  in  1  pixel clock (25 MHz); one clock domain; reset is synchronous and active-high
- `rst`  in  1  synchronous, active-high reset
- `scroll_en`  in  1  enables the per-frame xoffset update
- `scroll_speed`  in  5  signed pixels per frame, -16..+15
- `hcount_out`  out  10  pixel column, 0..799
- `hsync_out`  out  1  horizontal sync, active low
- `vcount_out`  out  10  line, 0..524
- `vsync_out`  out  1  vertical sync, active low
- `blnk_out`  out  1  high outside the visible area
- `rgb_out`  out  24  `BG_COLOR` when visible, 0 when blanked
- `xoffset_out`  out  10  scroll offset, 0..`SCROLL_WRAP`-1
- `frame_start`  out  1  one-cycle pulse while hcount_out==0 && vcount_out==0

## Operation
- H counter 0..H_TOTAL-1 (800); at 799 wraps to 0 and increments V counter; V counter 0..V_TOTAL-1 (525), wraps at 524.
- All outputs are registers and are mutually consistent in the same cycle: they describe the pixel at (hcount_out, vcount_out).
- hsync_out = 0 iff 656 <= hcount <= 751; vsync_out = 0 iff 490 <= vcount <= 491.
- blnk_out = 1 iff hcount >= 640 or vcount >= 480; rgb_out = blnk ? 0 : BG_COLOR.
- Scroll update: on the edge where hcount==799 && vcount==479 (last visible pixel), if scroll_en, xoffset <= wrap(xoffset + scroll_speed). scroll_speed is sampled on that edge only. The offset therefore changes exactly once per frame, during vertical blank.
- wrap(): 11-bit signed sum s; s<0 -> s+640; s>=640 -> s-640; else s. One correction is always sufficient since |speed| < 640.
- Reset values: hcount_out 0, vcount_out 0, hsync_out 1, vsync_out 1, blnk_out 0, rgb_out BG_COLOR, xoffset_out 0, frame_start 1. These are the (0,0) pixel values, so the raster restarts cleanly.
- Reset mid-frame: the next cycle after rst deasserts shows (1,0); no partial sync pulse is carried across reset.

## Timing
- Zero latency between counters and the decoded sync/blank/rgb: decodes are computed from the next-state counter values and registered with them.
- Line period 800 clk; frame period 420 000 clk; hsync low 96 clk starting at hcount 656; vsync low 1600 clk starting at (0,490).
- xoffset_out new value is first visible at (hcount 0, vcount 480). It is stable from (0,0) through the whole visible frame.
- Downstream stages each add one register stage. The consumer compensates; this block does not.

## Structure
- Package `vga_pkg`: H_/V_ timing constants, H_TOTAL/V_TOTAL, sync start/end localparams, XRES/YRES, and shared 24-bit colour constants such as the cloud and sky colours.
- Sub-module `scroll_accum`: holds the xoffset register and the signed modular add. Inputs: update strobe, enable, speed. Output: xoffset.
- Top level: the two counters, the next-state decode and the output registers.

## Test plan
- Reset held 5 clk, then released -> outputs step (0,0),(1,0),…; frame_start high only at (0,0); hsync/vsync 1; xoffset_out 0.
- Run 2 lines -> hsync_out low exactly for hcount 656..751; blnk_out rises at hcount 640; vcount increments at the hcount 799->0 edge.
- Run 1 full frame -> 420 000 clk between frame_start pulses; vsync low for lines 490..491 only; rgb_out 0 whenever blnk_out.
- scroll_en=1, speed=+7, xoffset 635 -> after (799,479) xoffset_out = 2; unchanged for the next 419 999 clk.
- scroll_en=1, speed=-16, xoffset 5 -> 629. Separately: speed changes mid-frame -> only the value present at (799,479) is applied; scroll_en=0 -> offset held.
- rst asserted at (300,200) for 1 clk -> next cycle (0,0) with reset values; xoffset_out 0; no stray sync pulse.
